// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
// No logic of its own: state encoding, port-select values, default region split.
// Nothing here stalls; the users of these types handle flow control.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef logic sel_t;

    localparam sel_t SEL_IF = 1'b0;
    localparam sel_t SEL_D  = 1'b1;

    localparam int DEF_DATA_OFFSET = 32;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requests; MEM_ARB_RR_EN selects round-robin.
// Purely combinational, zero latency.
// Does not stall; the losing request simply stays pending at the caller.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  sel_t last_sel,
    output logic any_req,
    output sel_t sel
);

    assign any_req = if_req | d_req;

`ifdef MEM_ARB_RR_EN
    // On a tie the port that did not win last time goes first.
    always_comb begin
        sel = SEL_IF;
        if (if_req && d_req)
            sel = (last_sel == SEL_D) ? SEL_IF : SEL_D;
        else if (d_req)
            sel = SEL_D;
    end
`else
    logic unused_last_sel;
    assign unused_last_sel = last_sel;

    always_comb begin
        sel = d_req ? SEL_D : SEL_IF;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares single-port mem between fetch and load/store ports; optional MEM_ARB_RR_EN.
// Request-to-ack latency 3 cycles, one access every 4 cycles.
// Requesters hold req until ack; the loser waits and is re-sampled in IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 64,
    parameter int DATA_OFFSET = DEF_DATA_OFFSET
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic [ADDR_W-1:0] OFFS = ADDR_W'(DATA_OFFSET);

    state_t state;
    sel_t   cur_sel;
    sel_t   last_sel;
    logic   cur_rd;
    logic   cur_blk;

    logic   any_req;
    sel_t   sel;
    logic   pick_d;
    logic   blk;

    mem_arb_pick u_pick (
        .if_req   (if_req),
        .d_req    (d_req),
        .last_sel (last_sel),
        .any_req  (any_req),
        .sel      (sel)
    );

    assign pick_d = (sel == SEL_D);
    // Writes into instruction space run the full access as a read, leaving mem untouched.
    assign blk    = pick_d && d_we && (d_addr < OFFS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cur_sel     <= SEL_IF;
            last_sel    <= SEL_IF;
            cur_rd      <= 1'b0;
            cur_blk     <= 1'b0;
            if_ack      <= 1'b0;
            if_rdata    <= '0;
            d_ack       <= 1'b0;
            d_err       <= 1'b0;
            d_rdata     <= '0;
            mem_mode    <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            d_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        cur_sel     <= sel;
                        last_sel    <= sel;
                        cur_rd      <= !(pick_d && d_we);
                        cur_blk     <= blk;
                        mem_addr    <= pick_d ? d_addr : if_addr;
                        mem_mode    <= pick_d && d_we && !blk;
                        mem_data_in <= pick_d ? d_wdata : mem_data_in;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_mode <= 1'b0;
                    state    <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (cur_sel == SEL_D) begin
                        if (cur_rd)
                            d_rdata <= mem_data_out;
                        d_ack <= 1'b1;
                        d_err <= cur_blk;
                    end else begin
                        if_rdata <= mem_data_out;
                        if_ack   <= 1'b1;
                    end
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port 128×64 `mem` between the CPU's instruction-fetch port and its load/store data port. Each request is sequenced as one `mem` access: read or write, with a fixed three-cycle latency. Data-port writes into the instruction region (addresses below `DATA_OFFSET`) are blocked and reported. The block sits between the core and `mem` and is the only driver of `mem`'s `mode`, `addr` and `data_in`.

## Interface
- `ADDR_W`, 7: `mem` address width.
- `DATA_W`, 64: `mem` word width.
- `DATA_OFFSET`, 32: first data-region address; below it is instruction space.
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch request, held until `if_ack`.
- `if_addr` in ADDR_W: fetch address.
- `if_ack` out 1: one-cycle completion pulse.
- `if_rdata` out DATA_W: fetched word.
- `d_req` in 1: data request, held until `d_ack`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: write data.
- `d_ack` out 1: one-cycle completion pulse.
- `d_err` out 1: valid with `d_ack`; 1 = blocked write.
- `d_rdata` out DATA_W: read word.
- `mem_mode` out 1: to `mem.mode`; 0 = read, 1 = write.
- `mem_addr` out ADDR_W: to `mem.addr`.
- `mem_data_in` out DATA_W: to `mem.data_in`.
- `mem_data_out` in DATA_W: from `mem.data_out`; registered, valid the cycle after the address is sampled.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE: requests are sampled at each edge. If any is pending, the arbiter picks a winner, registers `mem_addr`/`mem_mode`/`mem_data_in` and moves to ISSUE. Otherwise it stays in IDLE.
- ISSUE: `mem` samples the access at the end of this cycle, then the FSM moves to CAPTURE.
- CAPTURE: the winner's `*_rdata` is loaded from `mem_data_out`, and for reads only. `mem_mode` returns to 0. The FSM moves to DONE.
- DONE: the winner's ack is high for exactly this cycle, then the FSM returns to IDLE unconditionally.
- Default arbitration is fixed priority: data beats fetch.
- Blocked write: `d_we`=1 with `d_addr` < `DATA_OFFSET`.
  - `mem_mode` stays 0 for the whole access, so `mem` is not written.
  - Same latency as a normal access; `d_err`=1 with `d_ack`.
  - `d_rdata` is left unchanged.
- `d_err` is 0 on every non-blocked ack.
- Fetch is read-only, and any `if_addr` is allowed.
- `*_rdata` holds its value until that port's next read completes.
- Requester inputs are sampled only in IDLE. Changes in any other state are ignored.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Last-grant pointer = fetch.
- Reset mid-access aborts it:
  - No ack is issued.
  - `mem_mode` is 0 from the reset edge onward.
  - A write in ISSUE at the reset edge is not guaranteed to commit.

## Timing
- `req` sampled at edge E0 → `mem` signals valid E0–E1 → `mem` samples at E1 → captured at E2 → ack high E2–E3.
- Request-to-ack latency: 3 cycles.
- Throughput: one access per 4 cycles, because DONE always returns to IDLE.
- If `req` is still high at the edge ending DONE (E3), it is ignored. If it is still high at E4, it counts as a new request.
- Both requests pending in IDLE: the loser waits for the winner's access to finish, then is sampled again in IDLE.
- `mem_mode`=1 lasts exactly one cycle (ISSUE) per unblocked write.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On a tie, the port not granted last wins. The last-grant pointer updates on each grant and resets to fetch, so data wins the first tie.
- Undefined: fixed priority, data over fetch. Fetch can starve under continuous data traffic; that is accepted.

## Structure
- Shared package `mem_arb_pkg`:
  - FSM state encoding (2 bits).
  - Port-select encoding (`SEL_IF`=0, `SEL_D`=1).
  - Default `DATA_OFFSET`.
- One sub-module, `mem_arb_pick`: combinational winner select from `if_req`, `d_req` and the last-grant pointer. The round-robin versus fixed-priority choice lives here under `MEM_ARB_RR_EN`.
- The FSM and datapath registers stay in `mem_arbiter`.

## Test plan
- Data write `d_addr`=33, `d_wdata`=64'h00ABCDEF, then data read addr 33 → writes with `mem_mode`=1 for one cycle; read gives `d_ack` at req+3 with `d_rdata`=64'h00ABCDEF and `d_err`=0.
- Fetch `if_addr`=5 with `mem` word 5 = 64'h1234 → `if_ack` 3 cycles later, `if_rdata`=64'h1234, `d_ack` stays 0.
- Data write `d_addr`=10 (< 32) → `mem_mode` never 1, `d_ack`=1 with `d_err`=1, word 10 unchanged on read-back.
- `if_req` and `d_req` asserted together and held continuously:
  - Fixed priority: all grants go to data.
  - `MEM_ARB_RR_EN`: grant order is D, IF, D, IF, with acks 4 cycles apart.
- `reset` pulsed during CAPTURE of a data read → no `d_ack`, all outputs 0 the next cycle, FSM in IDLE. A new fetch then completes normally in 3 cycles.
